// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared pipeline definitions for the EXE -> MEM -> WB boundary:
//   - bus widths for EXE_to_MEM_bus, MEM_to_WB_bus and MEM_fwd_bus
//   - LSB offsets of every field on the two stage buses
//   - packed structs whose member order matches the bus layouts, MSB first
// ----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int EXE_TO_MEM_BUS_W = 213;
   localparam int MEM_TO_WB_BUS_W  = 207;
   localparam int MEM_FWD_BUS_W    = 39;

   // EXE_to_MEM_bus field LSB offsets
   localparam int EM_DEST_LSB         = 0;
   localparam int EM_GR_WE_LSB        = 5;
   localparam int EM_RES_FROM_MEM_LSB = 6;
   localparam int EM_ALU_RESULT_LSB   = 7;
   localparam int EM_PC_LSB           = 39;
   localparam int EM_OP_H_LSB         = 71;
   localparam int EM_OP_B_LSB         = 72;
   localparam int EM_UNSIGNED_LD_LSB  = 73;
   localparam int EM_VADDR_LSB        = 74;
   localparam int EM_CSR_NUM_LSB      = 76;
   localparam int EM_CSRXCHG_LSB      = 90;
   localparam int EM_CSRWR_LSB        = 91;
   localparam int EM_CSRRD_LSB        = 92;
   localparam int EM_ERTN_LSB         = 93;
   localparam int EM_SYSCALL_LSB      = 94;
   localparam int EM_RKD_LSB          = 95;
   localparam int EM_RJ_LSB           = 127;
   localparam int EM_EX_CODE_LSB      = 159;
   localparam int EM_RDCNTVH_W_LSB    = 174;
   localparam int EM_RDCNTVL_W_LSB    = 175;
   localparam int EM_RDCNTID_LSB      = 176;
   localparam int EM_BRK_LSB          = 177;
   localparam int EM_EX_BADDR_LSB     = 178;
   localparam int EM_EX_ALE_LSB       = 210;
   localparam int EM_EX_INE_LSB       = 211;
   localparam int EM_EX_ADEF_LSB      = 212;

   // MEM_to_WB_bus field LSB offsets
   localparam int MW_DEST_LSB         = 0;
   localparam int MW_GR_WE_LSB        = 5;
   localparam int MW_FINAL_RESULT_LSB = 6;
   localparam int MW_PC_LSB           = 38;
   localparam int MW_CSR_NUM_LSB      = 70;
   localparam int MW_CSRXCHG_LSB      = 84;
   localparam int MW_CSRWR_LSB        = 85;
   localparam int MW_CSRRD_LSB        = 86;
   localparam int MW_ERTN_LSB         = 87;
   localparam int MW_SYSCALL_LSB      = 88;
   localparam int MW_RKD_LSB          = 89;
   localparam int MW_RJ_LSB           = 121;
   localparam int MW_EX_CODE_LSB      = 153;
   localparam int MW_RDCNTVH_W_LSB    = 168;
   localparam int MW_RDCNTVL_W_LSB    = 169;
   localparam int MW_RDCNTID_LSB      = 170;
   localparam int MW_BRK_LSB          = 171;
   localparam int MW_EX_BADDR_LSB     = 172;
   localparam int MW_EX_ALE_LSB       = 204;
   localparam int MW_EX_INE_LSB       = 205;
   localparam int MW_EX_ADEF_LSB      = 206;

   typedef struct packed {
      logic        ex_adef;
      logic        ex_ine;
      logic        ex_ale;
      logic [31:0] ex_baddr;
      logic        brk;
      logic        rdcntid;
      logic        rdcntvl_w;
      logic        rdcntvh_w;
      logic [14:0] ex_code;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        syscall;
      logic        ertn;
      logic        csrrd;
      logic        csrwr;
      logic        csrxchg;
      logic [13:0] csr_num;
      logic [1:0]  vaddr;
      logic        unsigned_ld;
      logic        op_b;
      logic        op_h;
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
   } exe_to_mem_bus_t;

   typedef struct packed {
      logic        ex_adef;
      logic        ex_ine;
      logic        ex_ale;
      logic [31:0] ex_baddr;
      logic        brk;
      logic        rdcntid;
      logic        rdcntvl_w;
      logic        rdcntvh_w;
      logic [14:0] ex_code;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        syscall;
      logic        ertn;
      logic        csrrd;
      logic        csrwr;
      logic        csrxchg;
      logic [13:0] csr_num;
      logic [31:0] pc;
      logic [31:0] final_result;
      logic        gr_we;
      logic [4:0]  dest;
   } mem_to_wb_bus_t;

endpackage

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load-data alignment and extension.
//   rdata       : 32-bit word read from data SRAM
//   vaddr       : low two address bits of the load
//   op_b / op_h : byte / half load (neither set = word load)
//   unsigned_ld : zero-extend when 1, sign-extend when 0
//   data        : aligned, extended 32-bit result
// ----------------------------------------------------------------------------
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  vaddr,
   input  logic        op_b,
   input  logic        op_h,
   input  logic        unsigned_ld,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      byte_sel = rdata[7:0];
      case (vaddr)
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         2'b11:   byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   assign half_sel = vaddr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      data = rdata;
      if (op_b) begin
         data = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      end else if (op_h) begin
         data = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipeline: registers the EXE payload, aligns/extends
// load data from the data SRAM, and offers the result to WB.
//   clk, reset        : clock (rising edge), async active-high reset
//   WB_allowin        : WB accepts an instruction this cycle
//   MEM_allowin       : MEM accepts from EXE
//   EXE_to_MEM_valid  : EXE offers an instruction
//   EXE_to_MEM_bus    : EXE payload
//   data_sram_rdata   : SRAM read data, valid the cycle after the EXE request
//   exec_flush        : exception/ertn flush from WB
//   MEM_to_WB_valid   : payload offered to WB
//   MEM_to_WB_bus     : WB payload
//   MEM_fwd_bus       : {we, dest, result, is_csr_or_cnt} bypass to ID
//   MEM_ex_out        : valid MEM instruction carries an exception or ertn
//   out_MEM_valid     : raw MEM valid
// ----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        WB_allowin,
   output logic                        MEM_allowin,
   input  logic                        EXE_to_MEM_valid,
   input  logic [EXE_TO_MEM_BUS_W-1:0] EXE_to_MEM_bus,
   input  logic [31:0]                 data_sram_rdata,
   input  logic                        exec_flush,
   output logic                        MEM_to_WB_valid,
   output logic [MEM_TO_WB_BUS_W-1:0]  MEM_to_WB_bus,
   output logic [MEM_FWD_BUS_W-1:0]    MEM_fwd_bus,
   output logic                        MEM_ex_out,
   output logic                        out_MEM_valid
);

   logic            mem_valid;
   exe_to_mem_bus_t bus_r;
   logic            rdata_buf_valid;
   logic [31:0]     rdata_buf;
   logic [31:0]     load_src;
   logic [31:0]     load_data;
   logic [31:0]     final_result;
   logic            advance;
   mem_to_wb_bus_t  wb_bus;

   // MEM always completes in one cycle, so readiness is just downstream space.
   assign MEM_allowin     = ~mem_valid | WB_allowin;
   assign MEM_to_WB_valid = mem_valid;
   assign out_MEM_valid   = mem_valid;
   assign advance         = mem_valid & WB_allowin;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_valid <= 1'b0;
         bus_r     <= '0;
      end else begin
         if (exec_flush) begin
            mem_valid <= 1'b0;
         end else if (MEM_allowin) begin
            mem_valid <= EXE_to_MEM_valid;
         end
         if (MEM_allowin && EXE_to_MEM_valid) begin
            bus_r <= exe_to_mem_bus_t'(EXE_to_MEM_bus);
         end
      end
   end

   // The SRAM only presents read data for one cycle. If WB stalls, the word
   // is captured on the first stalled edge and used until the instruction
   // leaves, so the WB payload stays stable for the whole stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_buf_valid <= 1'b0;
         rdata_buf       <= '0;
      end else if (exec_flush || advance) begin
         rdata_buf_valid <= 1'b0;
      end else if (mem_valid && !rdata_buf_valid) begin
         rdata_buf_valid <= 1'b1;
         rdata_buf       <= data_sram_rdata;
      end
   end

   assign load_src = rdata_buf_valid ? rdata_buf : data_sram_rdata;

   load_align u_load_align (
      .rdata       (load_src),
      .vaddr       (bus_r.vaddr),
      .op_b        (bus_r.op_b),
      .op_h        (bus_r.op_h),
      .unsigned_ld (bus_r.unsigned_ld),
      .data        (load_data)
   );

   assign final_result = bus_r.res_from_mem ? load_data : bus_r.alu_result;

   assign MEM_ex_out = mem_valid & (bus_r.ex_adef | bus_r.ex_ine | bus_r.ex_ale |
                                    bus_r.syscall | bus_r.brk | bus_r.ertn);

   // A faulting instruction never writes its destination, so it must not
   // be offered for bypass either.
   assign MEM_fwd_bus = {mem_valid & bus_r.gr_we & ~MEM_ex_out,
                         bus_r.dest,
                         final_result,
                         bus_r.csrrd | bus_r.csrwr | bus_r.csrxchg |
                         bus_r.rdcntid | bus_r.rdcntvl_w | bus_r.rdcntvh_w};

   always_comb begin
      wb_bus              = '0;
      wb_bus.ex_adef      = bus_r.ex_adef;
      wb_bus.ex_ine       = bus_r.ex_ine;
      wb_bus.ex_ale       = bus_r.ex_ale;
      wb_bus.ex_baddr     = bus_r.ex_baddr;
      wb_bus.brk          = bus_r.brk;
      wb_bus.rdcntid      = bus_r.rdcntid;
      wb_bus.rdcntvl_w    = bus_r.rdcntvl_w;
      wb_bus.rdcntvh_w    = bus_r.rdcntvh_w;
      wb_bus.ex_code      = bus_r.ex_code;
      wb_bus.rj           = bus_r.rj;
      wb_bus.rkd          = bus_r.rkd;
      wb_bus.syscall      = bus_r.syscall;
      wb_bus.ertn         = bus_r.ertn;
      wb_bus.csrrd        = bus_r.csrrd;
      wb_bus.csrwr        = bus_r.csrwr;
      wb_bus.csrxchg      = bus_r.csrxchg;
      wb_bus.csr_num      = bus_r.csr_num;
      wb_bus.pc           = bus_r.pc;
      wb_bus.final_result = final_result;
      wb_bus.gr_we        = bus_r.gr_we;
      wb_bus.dest         = bus_r.dest;
   end

   assign MEM_to_WB_bus = wb_bus;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed, self-checking bench for mem_stage. Bus vectors are built from a
// local field struct laid out MSB first; expected results are hand-computed.
// ----------------------------------------------------------------------------
module tb_mem_stage;

   typedef struct packed {
      logic        ex_adef;
      logic        ex_ine;
      logic        ex_ale;
      logic [31:0] ex_baddr;
      logic        brk;
      logic        rdcntid;
      logic        rdcntvl_w;
      logic        rdcntvh_w;
      logic [14:0] ex_code;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        syscall;
      logic        ertn;
      logic        csrrd;
      logic        csrwr;
      logic        csrxchg;
      logic [13:0] csr_num;
      logic [1:0]  vaddr;
      logic        unsigned_ld;
      logic        op_b;
      logic        op_h;
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
   } exe_f_t;

   logic          clk;
   logic          reset;
   logic          WB_allowin;
   logic          MEM_allowin;
   logic          EXE_to_MEM_valid;
   logic [212:0]  EXE_to_MEM_bus;
   logic [31:0]   data_sram_rdata;
   logic          exec_flush;
   logic          MEM_to_WB_valid;
   logic [206:0]  MEM_to_WB_bus;
   logic [38:0]   MEM_fwd_bus;
   logic          MEM_ex_out;
   logic          out_MEM_valid;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage dut (
      .clk              (clk),
      .reset            (reset),
      .WB_allowin       (WB_allowin),
      .MEM_allowin      (MEM_allowin),
      .EXE_to_MEM_valid (EXE_to_MEM_valid),
      .EXE_to_MEM_bus   (EXE_to_MEM_bus),
      .data_sram_rdata  (data_sram_rdata),
      .exec_flush       (exec_flush),
      .MEM_to_WB_valid  (MEM_to_WB_valid),
      .MEM_to_WB_bus    (MEM_to_WB_bus),
      .MEM_fwd_bus      (MEM_fwd_bus),
      .MEM_ex_out       (MEM_ex_out),
      .out_MEM_valid    (out_MEM_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [206:0] got, input logic [206:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction for exactly one cycle (MEM must be able to accept).
   task automatic send(input exe_f_t f);
      EXE_to_MEM_valid = 1'b1;
      EXE_to_MEM_bus   = f;
      tick();
      EXE_to_MEM_valid = 1'b0;
   endtask

   function automatic exe_f_t mk_load(input logic [1:0] va, input logic uns,
                                      input logic b, input logic h, input logic [4:0] rd);
      exe_f_t f;
      f              = '0;
      f.vaddr        = va;
      f.unsigned_ld  = uns;
      f.op_b         = b;
      f.op_h         = h;
      f.pc           = 32'h1C00_0100 + {27'd0, rd, 2'b00};
      f.alu_result   = {30'h0400_0000, va};
      f.res_from_mem = 1'b1;
      f.gr_we        = 1'b1;
      f.dest         = rd;
      return f;
   endfunction

   // Expected WB payload for the given EXE fields and final result.
   function automatic logic [206:0] wb_of(input exe_f_t f, input logic [31:0] res);
      return {f.ex_adef, f.ex_ine, f.ex_ale, f.ex_baddr, f.brk, f.rdcntid,
              f.rdcntvl_w, f.rdcntvh_w, f.ex_code, f.rj, f.rkd, f.syscall,
              f.ertn, f.csrrd, f.csrwr, f.csrxchg, f.csr_num, f.pc, res,
              f.gr_we, f.dest};
   endfunction

   // Directed load vectors: {vaddr, unsigned, op_b, op_h, rdata, expected}
   typedef struct {
      logic [1:0]  va;
      logic        uns;
      logic        b;
      logic        h;
      logic [31:0] rd;
      logic [31:0] exp;
   } ld_vec_t;

   ld_vec_t vecs[9] = '{
      '{2'b11, 1'b0, 1'b1, 1'b0, 32'h80AB_CDEF, 32'hFFFF_FF80},
      '{2'b11, 1'b1, 1'b1, 1'b0, 32'h80AB_CDEF, 32'h0000_0080},
      '{2'b00, 1'b1, 1'b1, 1'b0, 32'h80AB_CDEF, 32'h0000_00EF},
      '{2'b01, 1'b0, 1'b1, 1'b0, 32'h80AB_CDEF, 32'hFFFF_FFCD},
      '{2'b10, 1'b0, 1'b1, 1'b0, 32'h80AB_CDEF, 32'hFFFF_FFAB},
      '{2'b00, 1'b0, 1'b0, 1'b1, 32'h1234_8765, 32'hFFFF_8765},
      '{2'b10, 1'b0, 1'b0, 1'b1, 32'h1234_8765, 32'h0000_1234},
      '{2'b00, 1'b1, 1'b0, 1'b1, 32'h1234_8765, 32'h0000_8765},
      '{2'b00, 1'b0, 1'b0, 1'b0, 32'h1234_8765, 32'h1234_8765}
   };

   initial begin
      exe_f_t f;

      reset            = 1'b1;
      WB_allowin       = 1'b1;
      EXE_to_MEM_valid = 1'b0;
      EXE_to_MEM_bus   = '0;
      data_sram_rdata  = 32'h0;
      exec_flush       = 1'b0;

      // Reset state
      #2;
      check("rst_to_wb_valid", {206'd0, MEM_to_WB_valid}, 207'd0);
      check("rst_ex_out",      {206'd0, MEM_ex_out},      207'd0);
      check("rst_fwd_we",      {206'd0, MEM_fwd_bus[38]}, 207'd0);
      check("rst_allowin",     {206'd0, MEM_allowin},     207'd1);
      check("rst_mem_valid",   {206'd0, out_MEM_valid},   207'd0);
      check("rst_wb_bus",      MEM_to_WB_bus,             207'd0);
      tick();
      reset = 1'b0;

      // Load alignment / extension vectors
      foreach (vecs[i]) begin
         f = mk_load(vecs[i].va, vecs[i].uns, vecs[i].b, vecs[i].h, 5'(i + 1));
         send(f);
         data_sram_rdata = vecs[i].rd;
         #1;
         check($sformatf("ld%0d_valid", i), {206'd0, MEM_to_WB_valid}, 207'd1);
         check($sformatf("ld%0d_wb_bus", i), MEM_to_WB_bus, wb_of(f, vecs[i].exp));
         check($sformatf("ld%0d_fwd", i), {168'd0, MEM_fwd_bus},
               {168'd0, 1'b1, f.dest, vecs[i].exp, 1'b0});
      end

      // Non-load with CSR read: ALU result forwarded, is_csr_or_cnt set
      f            = '0;
      f.alu_result = 32'h0BAD_F00D;
      f.csrrd      = 1'b1;
      f.csr_num    = 14'h0005;
      f.gr_we      = 1'b1;
      f.dest       = 5'd12;
      f.pc         = 32'h1C00_0200;
      send(f);
      data_sram_rdata = 32'h5555_AAAA;
      #1;
      check("alu_wb_bus", MEM_to_WB_bus, wb_of(f, 32'h0BAD_F00D));
      check("alu_fwd", {168'd0, MEM_fwd_bus}, {168'd0, 1'b1, 5'd12, 32'h0BAD_F00D, 1'b1});
      tick();
      check("drain_valid", {206'd0, out_MEM_valid}, 207'd0);

      // WB stall: word load held across 3 stalled cycles while SRAM data changes
      f = mk_load(2'b00, 1'b0, 1'b0, 1'b0, 5'd7);
      send(f);
      WB_allowin      = 1'b0;
      data_sram_rdata = 32'h1122_3344;
      #1;
      check("stall0_allowin", {206'd0, MEM_allowin}, 207'd0);
      check("stall0_wb_bus", MEM_to_WB_bus, wb_of(f, 32'h1122_3344));
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check("stall1_allowin", {206'd0, MEM_allowin}, 207'd0);
      check("stall1_wb_bus", MEM_to_WB_bus, wb_of(f, 32'h1122_3344));
      tick();
      check("stall2_allowin", {206'd0, MEM_allowin}, 207'd0);
      check("stall2_wb_bus", MEM_to_WB_bus, wb_of(f, 32'h1122_3344));
      tick();
      WB_allowin = 1'b1;
      #1;
      check("release_valid", {206'd0, MEM_to_WB_valid}, 207'd1);
      check("release_allowin", {206'd0, MEM_allowin}, 207'd1);
      check("release_wb_bus", MEM_to_WB_bus, wb_of(f, 32'h1122_3344));
      tick();
      check("after_release_valid", {206'd0, out_MEM_valid}, 207'd0);

      // Flush coinciding with an EXE handshake: flush wins
      f = mk_load(2'b00, 1'b0, 1'b0, 1'b0, 5'd9);
      exec_flush = 1'b1;
      send(f);
      exec_flush = 1'b0;
      check("flush_mem_valid", {206'd0, out_MEM_valid}, 207'd0);
      check("flush_to_wb_valid", {206'd0, MEM_to_WB_valid}, 207'd0);
      check("flush_fwd_we", {206'd0, MEM_fwd_bus[38]}, 207'd0);

      // Misaligned-address exception: no forwarding, ex_baddr passes to WB
      f            = '0;
      f.ex_ale     = 1'b1;
      f.ex_baddr   = 32'hCAFE_0003;
      f.ex_code    = 15'h0009;
      f.alu_result = 32'hCAFE_0003;
      f.gr_we      = 1'b1;
      f.dest       = 5'd4;
      f.pc         = 32'h1C00_0300;
      send(f);
      #1;
      check("ale_ex_out", {206'd0, MEM_ex_out}, 207'd1);
      check("ale_fwd_we", {206'd0, MEM_fwd_bus[38]}, 207'd0);
      check("ale_baddr", {175'd0, MEM_to_WB_bus[203:172]}, {175'd0, 32'hCAFE_0003});
      check("ale_wb_bus", MEM_to_WB_bus, wb_of(f, 32'hCAFE_0003));
      tick();

      // Asynchronous reset in the middle of a stall
      f = mk_load(2'b01, 1'b1, 1'b1, 1'b0, 5'd15);
      send(f);
      WB_allowin      = 1'b0;
      data_sram_rdata = 32'h0000_7700;
      tick();
      check("pre_rst_valid", {206'd0, out_MEM_valid}, 207'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_to_wb_valid", {206'd0, MEM_to_WB_valid}, 207'd0);
      check("arst_ex_out", {206'd0, MEM_ex_out}, 207'd0);
      check("arst_fwd", {168'd0, MEM_fwd_bus}, 207'd0);
      check("arst_allowin", {206'd0, MEM_allowin}, 207'd1);
      check("arst_wb_bus", MEM_to_WB_bus, 207'd0);
      tick();
      reset      = 1'b0;
      WB_allowin = 1'b1;
      tick();
      check("no_replay_valid", {206'd0, out_MEM_valid}, 207'd0);
      check("no_replay_wb_bus", MEM_to_WB_bus, 207'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
